// File: rtl/tpu_pkg.sv
// tpu_pkg: shared SRAM geometry and read-streamer FSM state type.
package tpu_pkg;
  localparam int SRAM_WORDS = 256;
  localparam int SRAM_ADDR_W = 10;
  localparam int DATA_W = 32;
  localparam int LANE_W = 8;
  typedef enum logic [1:0] {RS_IDLE, RS_ISSUE, RS_DRAIN, RS_DONE} rs_state_t;
endpackage

// File: rtl/stream_fifo.sv
// stream_fifo: synchronous FIFO with occupancy count, push and pop allowed together.
module stream_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32,
  parameter int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic [CW-1:0]    count,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr, rd;
  always_ff @(posedge clk) begin
    if (rst) begin
      wr <= '0;
      rd <= '0;
      count <= '0;
    end else begin
      if (push) wr <= (wr == AW'(DEPTH - 1)) ? '0 : wr + 1'b1;
      if (pop) rd <= (rd == AW'(DEPTH - 1)) ? '0 : rd + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem[wr] <= wdata;
  end
  assign rdata = mem[rd];
  assign empty = (count == '0);
endmodule

// File: rtl/sram_read_streamer.sv
// sram_read_streamer: walks an SRAM address range and streams the words out over valid/ready,
// issuing reads only when the output FIFO has room for every read already in flight.
module sram_read_streamer import tpu_pkg::*; #(
  parameter int ADDR_W = tpu_pkg::SRAM_ADDR_W,
  parameter int DATA_W = tpu_pkg::DATA_W,
  parameter int MEM_WORDS = tpu_pkg::SRAM_WORDS,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [$clog2(MEM_WORDS)-1:0]  base_addr,
  input  logic [$clog2(MEM_WORDS):0]    num_words,
  output logic                          busy,
  output logic                          done,
  output logic                          sram_csb,
  output logic [ADDR_W-1:0]             sram_raddr,
  input  logic [DATA_W-1:0]             sram_rdata,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DATA_W-1:0]             out_data,
  output logic                          out_last
);
  localparam int AW = $clog2(MEM_WORDS);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  rs_state_t state, state_n;
  logic [AW-1:0] addr;
  logic [AW:0] num, issued, sent;
  logic rv, issue, hs, empty, credit;
  logic [CW-1:0] occ;
  logic [DATA_W-1:0] fifo_data;
  stream_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(DATA_W)) u_fifo (
    .clk(clk), .rst(rst), .push(rv), .wdata(sram_rdata), .pop(hs),
    .rdata(fifo_data), .count(occ), .empty(empty)
  );
  // Credit counts the read on the SRAM port and the one returning now, so the FIFO can never overflow.
  assign credit = int'(occ) + int'(!sram_csb) + int'(rv) < FIFO_DEPTH;
  assign issue = (state == RS_ISSUE) && credit;
  assign out_valid = !empty;
  assign out_data = empty ? '0 : fifo_data;
  assign out_last = out_valid && (sent == num - 1'b1);
  assign hs = out_valid && out_ready;
  assign busy = (state != RS_IDLE);
  assign done = (state == RS_DONE);
  always_comb begin
    state_n = state;
    case (state)
      RS_IDLE:  state_n = start ? ((num_words == '0) ? RS_DONE : RS_ISSUE) : RS_IDLE;
      RS_ISSUE: state_n = (issue && issued == num - 1'b1) ? RS_DRAIN : RS_ISSUE;
      RS_DRAIN: state_n = (hs && out_last) ? RS_DONE : RS_DRAIN;
      default:  state_n = RS_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RS_IDLE;
      sram_csb <= 1'b1;
      sram_raddr <= '0;
      rv <= 1'b0;
      addr <= '0;
      num <= '0;
      issued <= '0;
      sent <= '0;
    end else begin
      state <= state_n;
      sram_csb <= !issue;
      rv <= !sram_csb;
      if (issue) begin
        sram_raddr <= ADDR_W'(addr);
        addr <= addr + 1'b1;
        issued <= issued + 1'b1;
      end
      if (hs) sent <= sent + 1'b1;
      if (state == RS_IDLE && start) begin
        addr <= base_addr;
        num <= num_words;
        issued <= '0;
        sent <= '0;
      end
    end
  end
endmodule

// File: tb/tb_sram_read_streamer.sv
// tb_sram_read_streamer: directed and random bursts checked against an address-order reference model.
module tb_sram_read_streamer;
  logic clk = 1'b0;
  logic rst, start, out_ready;
  logic [7:0] base_addr;
  logic [8:0] num_words;
  logic busy, done, sram_csb, out_valid, out_last;
  logic [9:0] sram_raddr;
  logic [31:0] sram_rdata, out_data;
  logic [31:0] mem [256];
  int n_cmp = 0;
  int n_err = 0;
  sram_read_streamer dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .num_words(num_words),
    .busy(busy), .done(done), .sram_csb(sram_csb), .sram_raddr(sram_raddr),
    .sram_rdata(sram_rdata), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last)
  );
  always #5 clk = ~clk;
  always @(posedge clk) if (!sram_csb) sram_rdata <= mem[sram_raddr[7:0]];
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic logic [31:0] word_at(input int a);
    logic [7:0] b;
    b = 8'(a % 256);
    return {b, b, b, b};
  endfunction
  task automatic chk_reset_vals();
    chk("rst_csb", 64'(sram_csb), 64'(1));
    chk("rst_raddr", 64'(sram_raddr), 64'(0));
    chk("rst_valid", 64'(out_valid), 64'(0));
    chk("rst_last", 64'(out_last), 64'(0));
    chk("rst_data", 64'(out_data), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
  endtask
  // mode: 0 ready held high, 1 ready pattern 1,0,0,1, 2 random ready
  task automatic run_burst(input int b, input int n, input int mode, input bit mid_start, input int rst_at);
    int cyc, iss, xf, first_csb, first_val, done_cyc;
    bit fin, stall, r;
    logic [31:0] pdata;
    logic plast;
    base_addr = 8'(b);
    num_words = 9'(n);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    base_addr = 8'($urandom);
    num_words = 9'($urandom_range(1, 256));
    cyc = 0; iss = 0; xf = 0; first_csb = -1; first_val = -1; done_cyc = -1;
    fin = 0; stall = 0; pdata = '0; plast = 1'b0;
    while (!fin) begin
      if (cyc > 3000) begin
        n_cmp++;
        n_err++;
        $error("FAIL timeout: observed cycle %0d without done, required done", cyc);
        break;
      end
      chk("busy", 64'(busy), 64'(1));
      if (!sram_csb) begin
        if (first_csb < 0) first_csb = cyc;
        chk("raddr", 64'(sram_raddr), 64'((b + iss) % 256));
        iss++;
      end
      chk("credit", 64'((iss - xf) <= 4), 64'(1));
      if (stall) begin
        chk("hold_valid", 64'(out_valid), 64'(1));
        chk("hold_data", 64'(out_data), 64'(pdata));
        chk("hold_last", 64'(out_last), 64'(plast));
      end
      if (out_valid) begin
        if (first_val < 0) first_val = cyc;
        chk("data", 64'(out_data), 64'(word_at(b + xf)));
        chk("last", 64'(out_last), 64'(xf == n - 1));
      end
      if (done) begin
        done_cyc = cyc;
        chk("done_count", 64'(xf), 64'(n));
        chk("done_valid", 64'(out_valid), 64'(0));
        fin = 1;
      end
      r = (mode == 0) ? 1'b1 : (mode == 1) ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'($urandom % 4 != 0);
      out_ready = r;
      stall = out_valid && !r;
      pdata = out_data;
      plast = out_last;
      if (out_valid && r) xf++;
      if (mid_start && cyc == 4) begin
        start = 1'b1;
        base_addr = 8'd100;
        num_words = 9'd5;
      end else start = 1'b0;
      if (rst_at >= 0 && xf == rst_at) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_reset_vals();
        for (int i = 0; i < 6; i++) begin
          @(negedge clk);
          chk("post_rst_done", 64'(done), 64'(0));
          chk("post_rst_valid", 64'(out_valid), 64'(0));
        end
        return;
      end
      if (!fin) begin
        @(negedge clk);
        cyc++;
      end
    end
    chk("total_xfers", 64'(xf), 64'(n));
    chk("total_issues", 64'(iss), 64'(n));
    if (mode == 0) begin
      chk("done_cycle", 64'(done_cyc), 64'((n == 0) ? 0 : n + 3));
      if (n > 0) begin
        chk("first_csb_cycle", 64'(first_csb), 64'(1));
        chk("first_valid_cycle", 64'(first_val), 64'(3));
      end
    end
    @(negedge clk);
    chk("idle_busy", 64'(busy), 64'(0));
    chk("idle_done", 64'(done), 64'(0));
  endtask
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = i * 32'h01010101;
    rst = 1'b1;
    start = 1'b0;
    out_ready = 1'b0;
    base_addr = '0;
    num_words = '0;
    repeat (2) @(negedge clk);
    chk_reset_vals();
    rst = 1'b0;
    @(negedge clk);
    run_burst(0, 8, 0, 1'b0, -1);
    run_burst(254, 4, 0, 1'b0, -1);
    run_burst(0, 8, 1, 1'b0, -1);
    run_burst(0, 0, 0, 1'b0, -1);
    run_burst(0, 8, 0, 1'b1, -1);
    run_burst(0, 8, 0, 1'b0, 3);
    run_burst(0, 256, 0, 1'b0, -1);
    for (int k = 0; k < 8; k++) run_burst(int'($urandom % 256), int'($urandom_range(1, 40)), 2, 1'b0, -1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
